// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, NUM_RD registered read ports with write-first
// bypass, and a soft-clear sweep that zeroes one register per cycle.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned NUM_RD   = 2,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     wr0_en_i,
    input  logic [AW-1:0]            wr0_addr_i,
    input  logic [DATA_W-1:0]        wr0_data_i,
    input  logic                     wr1_en_i,
    input  logic [AW-1:0]            wr1_addr_i,
    input  logic [DATA_W-1:0]        wr1_data_i,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic                     busy_o
);

    localparam logic [AW:0]   NumRegsExt = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LastIdx    = AW'(NUM_REGS - 1);

    typedef enum logic {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              wr0_ok, wr1_ok, zero_rd;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < NumRegsExt;
    endfunction

    assign wr0_ok  = wr0_en_i && in_range(wr0_addr_i);
    assign wr1_ok  = wr1_en_i && in_range(wr1_addr_i);
    assign busy_o  = (state_q == StClear);
    // Read outputs stay zero for the whole sweep, including the edge that enters it.
    assign zero_rd = (state_q == StClear) || (state_d == StClear);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LastIdx) begin
                    state_d   = StReady;
                    clr_cnt_d = '0;
                end
            end
            StReady: begin
                clr_cnt_d = '0;
                if (clr_i) begin
                    state_d = StClear;
                end
            end
            default: begin
                state_d   = StClear;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array has no reset; the sweep after reset release zeroes it. Port 1 assigned last wins.
    always_ff @(posedge clk_i) begin
        if (state_q == StClear) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            if (wr0_ok) mem_q[wr0_addr_i] <= wr0_data_i;
            if (wr1_ok) mem_q[wr1_addr_i] <= wr1_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] rd_q;

        assign addr = rd_addr_i[k*AW +: AW];

        always_comb begin
            val = '0;
            if (in_range(addr)) begin
                if (wr1_en_i && (wr1_addr_i == addr)) begin
                    val = wr1_data_i;
                end else if (wr0_en_i && (wr0_addr_i == addr)) begin
                    val = wr0_data_i;
                end else begin
                    val = mem_q[addr];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rd_q <= '0;
            end else if (zero_rd) begin
                rd_q <= '0;
            end else if (rd_en_i[k]) begin
                rd_q <= val;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a 16-register and a 12-register instance share all inputs.
module tb_reg_file_mp;

    localparam int DW  = 32;
    localparam int NRD = 2;
    localparam int AW  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              clr = 1'b0;
    logic              wr0_en = 1'b0, wr1_en = 1'b0;
    logic [AW-1:0]     wr0_addr = '0, wr1_addr = '0;
    logic [DW-1:0]     wr0_data = '0, wr1_data = '0;
    logic [NRD-1:0]    rd_en = '0;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*DW-1:0] rd_data, rd_data12;
    logic              busy, busy12;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .NUM_REGS(16), .NUM_RD(NRD)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .busy_o(busy)
    );

    reg_file_mp #(.DATA_W(DW), .NUM_REGS(12), .NUM_RD(NRD)) dut12 (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data12), .busy_o(busy12)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
        tick;
        rd_en   = 2'b00;
    endtask

    task automatic test_reset;
        int n, n12;
        rst_n = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd: got %h expected 0", rd_data); end
        tick;
        tick;
        rst_n = 1'b1;
        n   = 0;
        n12 = -1;
        while (busy && n < 40) begin
            tick;
            n++;
            if (!busy12 && n12 < 0) n12 = n;
        end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL sweep_len16: got %0d expected 16", n); end
        checks++;
        if (n12 !== 12) begin errors++; $display("FAIL sweep_len12: got %0d expected 12", n12); end
        for (int i = 0; i < 16; i += 2) begin
            rd2(AW'(i), AW'(i + 1));
            checks++;
            if (rd_data !== '0 || rd_data12 !== '0) begin
                errors++;
                $display("FAIL swept_zero r%0d: got %h / %h expected 0", i, rd_data, rd_data12);
            end
        end
    endtask

    task automatic test_write_read;
        wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'hDEADBEEF;
        tick;
        wr0_en  = 1'b0;
        rd_en   = 2'b10;
        rd_addr = {4'd5, 4'd0};
        tick;
        rd_en = 2'b00;
        checks++;
        if (rd_data[63:32] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_rd_p1: got %h expected deadbeef", rd_data[63:32]);
        end
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL hold_p0: got %h expected 0", rd_data[31:0]);
        end
    endtask

    task automatic test_collision;
        wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 4'd3; wr1_data = 32'h22;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
        tick;
        wr0_en = 1'b0; wr1_en = 1'b0; rd_en = 2'b00;
        checks++;
        if (rd_data[31:0] !== 32'h22) begin
            errors++; $display("FAIL bypass_p1_prio: got %h expected 22", rd_data[31:0]);
        end
        checks++;
        if (rd_data[63:32] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hold_p1: got %h expected deadbeef", rd_data[63:32]);
        end
        rd2(4'd3, 4'd5);
        checks++;
        if (rd_data !== {32'hDEADBEEF, 32'h22}) begin
            errors++; $display("FAIL r3_after: got %h expected deadbeef00000022", rd_data);
        end
        wr0_en = 1'b1; wr0_addr = 4'd7; wr0_data = 32'hA5A5A5A5;
        rd_en = 2'b10; rd_addr = {4'd7, 4'd0};
        tick;
        wr0_en = 1'b0; rd_en = 2'b00;
        checks++;
        if (rd_data[63:32] !== 32'hA5A5A5A5 || rd_data12[63:32] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_p0: got %h / %h expected a5a5a5a5",
                     rd_data[63:32], rd_data12[63:32]);
        end
        rd2(4'd7, 4'd7);
        checks++;
        if (rd_data !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            errors++; $display("FAIL same_addr: got %h expected a5a5a5a5a5a5a5a5", rd_data);
        end
        rd_addr = {4'd3, 4'd3};
        tick;
        checks++;
        if (rd_data !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            errors++; $display("FAIL rd_en_low_hold: got %h expected a5a5a5a5a5a5a5a5", rd_data);
        end
    endtask

    task automatic test_out_of_range;
        wr1_en = 1'b1; wr1_addr = 4'd11; wr1_data = 32'hCAFEF00D;
        tick;
        wr1_en = 1'b0;
        wr0_en = 1'b1; wr0_addr = 4'd13; wr0_data = 32'h12345678;
        tick;
        wr0_en = 1'b0;
        rd2(4'd13, 4'd11);
        checks++;
        if (rd_data12 !== {32'hCAFEF00D, 32'h0}) begin
            errors++; $display("FAIL oor12_read: got %h expected cafef00d00000000", rd_data12);
        end
        checks++;
        if (rd_data !== {32'hCAFEF00D, 32'h12345678}) begin
            errors++; $display("FAIL r13_in16: got %h expected cafef00d12345678", rd_data);
        end
        rd2(4'd1, 4'd9);
        checks++;
        if (rd_data12 !== '0) begin
            errors++; $display("FAIL oor12_alias: got %h expected 0", rd_data12);
        end
        wr0_en = 1'b1; wr0_addr = 4'd13; wr0_data = 32'h99;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd13};
        tick;
        wr0_en = 1'b0; rd_en = 2'b00;
        checks++;
        if (rd_data12[31:0] !== 32'h0 || rd_data[31:0] !== 32'h99) begin
            errors++;
            $display("FAIL oor_bypass: got %h / %h expected 0 / 99",
                     rd_data12[31:0], rd_data[31:0]);
        end
    endtask

    task automatic test_clear;
        int n;
        for (int i = 0; i < 8; i++) begin
            wr0_en = 1'b1; wr0_addr = AW'(2 * i);     wr0_data = 32'h100 + 32'(2 * i);
            wr1_en = 1'b1; wr1_addr = AW'(2 * i + 1); wr1_data = 32'h100 + 32'(2 * i + 1);
            tick;
        end
        wr0_en = 1'b0; wr1_en = 1'b0;
        rd2(4'd0, 4'd15);
        checks++;
        if (rd_data !== {32'h10F, 32'h100}) begin
            errors++; $display("FAIL fill: got %h expected 0000010f00000100", rd_data);
        end
        clr = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b1 || rd_data !== '0) begin
            errors++; $display("FAIL clr_enter: got busy %b rd %h expected 1 / 0", busy, rd_data);
        end
        // Hold writes, reads and clr high for the whole sweep.
        wr0_en = 1'b1; wr0_addr = 4'd2;  wr0_data = 32'hBAD;
        wr1_en = 1'b1; wr1_addr = 4'd15; wr1_data = 32'hBAD2;
        rd_en = 2'b11; rd_addr = {4'd15, 4'd2};
        n = 0;
        while (busy && n < 40) begin
            checks++;
            if (rd_data !== '0) begin
                errors++; $display("FAIL busy_rd_zero c%0d: got %h expected 0", n, rd_data);
            end
            tick;
            n++;
        end
        clr = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; rd_en = 2'b00;
        checks++;
        if (n !== 16) begin errors++; $display("FAIL clr_len: got %0d expected 16", n); end
        for (int i = 0; i < 16; i += 2) begin
            rd2(AW'(i), AW'(i + 1));
            checks++;
            if (rd_data !== '0) begin
                errors++; $display("FAIL cleared r%0d: got %h expected 0", i, rd_data);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 32'h5555AAAA;
        tick;
        wr0_en = 1'b0;
        rd2(4'd4, 4'd4);
        checks++;
        if (rd_data !== {32'h5555AAAA, 32'h5555AAAA}) begin
            errors++; $display("FAIL pre_reset_rd: got %h expected 5555aaaa5555aaaa", rd_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rd_data !== '0 || busy12 !== 1'b1 || rd_data12 !== '0) begin
            errors++;
            $display("FAIL async_rst: got busy %b rd %h expected 1 / 0", busy, rd_data);
        end
        tick;
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL rst_sweep_len: got %0d expected 16", n); end
        clr = 1'b1;
        tick;
        clr = 1'b0;
        repeat (7) tick;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rd_data !== '0) begin
            errors++; $display("FAIL mid_sweep_rst: got busy %b rd %h expected 1 / 0", busy, rd_data);
        end
        tick;
        tick;
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL restart_len: got %0d expected 16", n); end
        rd2(4'd4, 4'd15);
        checks++;
        if (rd_data !== '0) begin
            errors++; $display("FAIL post_restart_rd: got %h expected 0", rd_data);
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_write_read;
        test_collision;
        test_out_of_range;
        test_clear;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
